// File: rtl/approx_adder_err_monitor.sv
// Error-characterisation controller for N-bit approximate adders.
// Drives LFSR operand pairs to an external combinational adder, computes the
// exact sum internally and accumulates mismatch count, total and maximum
// error distance over a programmed number of tests.
// Optional macro APPROX_CARRY_CHECK_EN: compare N+1-bit {carry, sum} values
// instead of the N-bit sums only.
module approx_adder_err_monitor #(
    parameter int unsigned N  = 16,
    parameter int unsigned CW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [CW-1:0]   num_tests,
    input  logic [31:0]     seed,
    output logic [N-1:0]    op_a,
    output logic [N-1:0]    op_b,
    input  logic [N-1:0]    approx_sum,
    input  logic            approx_co,
    output logic            busy,
    output logic            done,
    output logic [CW-1:0]   err_cnt,
    output logic [N+CW-1:0] total_ed,
    output logic [N:0]      max_ed,
    output logic [CW-1:0]   tests_run
);

    localparam int unsigned EW  = N + 1;
    localparam int unsigned TW  = N + CW;
    localparam int unsigned TSW = TW + 1;
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state_q;
    logic [31:0]     lfsr_q;
    logic [CW-1:0]   remaining_q;
    logic            drain_q;
    logic [N-1:0]    op_a_q;
    logic [N-1:0]    op_b_q;
    logic            v0_q;
    logic            busy_q;
    logic            done_q;

    logic            v1_q;
    logic [EW-1:0]   ed_q;
    logic            mis_q;
    logic [CW-1:0]   err_cnt_q;
    logic [TW-1:0]   total_ed_q;
    logic [EW-1:0]   max_ed_q;
    logic [CW-1:0]   tests_run_q;

    logic            start_acc_c;
    logic [31:0]     lfsr_next_c;
    logic [EW-1:0]   exact_c;
    logic [EW-1:0]   approx_c;
    logic [EW-1:0]   ed_d;
    logic [TSW-1:0]  total_sum_c;
    logic            unused_c;

    // Start is only honoured when no run is in flight
    assign start_acc_c = start && ((state_q == S_IDLE) || (state_q == S_DONE));

    // Galois LFSR, shift right
    assign lfsr_next_c = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'h0);

    // Control FSM, LFSR and operand issue registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            lfsr_q      <= 32'h1;
            remaining_q <= '0;
            drain_q     <= 1'b0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            v0_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            v0_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_acc_c) begin
                        remaining_q <= num_tests;
                        lfsr_q      <= (seed == 32'h0) ? 32'h1 : seed;
                        drain_q     <= 1'b0;
                        if (num_tests == '0) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_RUN;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    op_a_q      <= lfsr_q[N-1:0];
                    op_b_q      <= lfsr_q[31:32-N];
                    lfsr_q      <= lfsr_next_c;
                    v0_q        <= 1'b1;
                    remaining_q <= remaining_q - CW'(1);
                    if (remaining_q == CW'(1)) begin
                        state_q <= S_DRAIN;
                        drain_q <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    // Two cycles let the last pair reach the accumulators
                    if (drain_q) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        drain_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Exact vs approximate operands for the error-distance compare
    always_comb begin
        exact_c  = '0;
        approx_c = '0;
`ifdef APPROX_CARRY_CHECK_EN
        exact_c  = {1'b0, op_a_q} + {1'b0, op_b_q};
        approx_c = {approx_co, approx_sum};
        unused_c = 1'b0;
`else
        exact_c  = {1'b0, N'(op_a_q + op_b_q)};
        approx_c = {1'b0, approx_sum};
        unused_c = approx_co;
`endif
    end

    // Absolute error distance
    always_comb begin
        ed_d = '0;
        if (exact_c >= approx_c) begin
            ed_d = exact_c - approx_c;
        end else begin
            ed_d = approx_c - exact_c;
        end
    end

    // Widened sum so total_ed overflow can be detected and saturated
    assign total_sum_c = {1'b0, total_ed_q} + TSW'(ed_q);

    // Compare stage and saturating accumulators
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q        <= 1'b0;
            ed_q        <= '0;
            mis_q       <= 1'b0;
            err_cnt_q   <= '0;
            total_ed_q  <= '0;
            max_ed_q    <= '0;
            tests_run_q <= '0;
        end else begin
            v1_q  <= v0_q;
            ed_q  <= ed_d;
            mis_q <= (ed_d != '0);
            if (start_acc_c) begin
                err_cnt_q   <= '0;
                total_ed_q  <= '0;
                max_ed_q    <= '0;
                tests_run_q <= '0;
            end else if (v1_q) begin
                if (tests_run_q != '1) begin
                    tests_run_q <= tests_run_q + CW'(1);
                end
                if (mis_q && (err_cnt_q != '1)) begin
                    err_cnt_q <= err_cnt_q + CW'(1);
                end
                total_ed_q <= total_sum_c[TSW-1] ? '1 : total_sum_c[TW-1:0];
                if (ed_q > max_ed_q) begin
                    max_ed_q <= ed_q;
                end
            end
        end
    end

    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err_cnt   = err_cnt_q;
    assign total_ed  = total_ed_q;
    assign max_ed    = max_ed_q;
    assign tests_run = tests_run_q;

endmodule

// File: tb/tb_approx_adder_err_monitor.sv
// Bench for approx_adder_err_monitor: table of runs with a behavioural
// adder, an LFSR reference model feeding an operand scoreboard, plus
// hand-written reset and restart sequences.
module tb_approx_adder_err_monitor;

    localparam int unsigned N  = 16;
    localparam int unsigned CW = 32;

    logic            clk;
    logic            rst;
    logic            start;
    logic [CW-1:0]   num_tests;
    logic [31:0]     seed;
    logic [N-1:0]    op_a;
    logic [N-1:0]    op_b;
    logic [N-1:0]    approx_sum;
    logic            approx_co;
    logic            busy;
    logic            done;
    logic [CW-1:0]   err_cnt;
    logic [N+CW-1:0] total_ed;
    logic [N:0]      max_ed;
    logic [CW-1:0]   tests_run;

    approx_adder_err_monitor #(.N(N), .CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_tests  (num_tests),
        .seed       (seed),
        .op_a       (op_a),
        .op_b       (op_b),
        .approx_sum (approx_sum),
        .approx_co  (approx_co),
        .busy       (busy),
        .done       (done),
        .err_cnt    (err_cnt),
        .total_ed   (total_ed),
        .max_ed     (max_ed),
        .tests_run  (tests_run)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Adder under test: 0 exact, 1 sum^1, 2 exact sum with carry forced 0, 3 sum=op_a
    int          mode;
    logic [16:0] ex_sum;
    always_comb begin
        ex_sum = {1'b0, op_a} + {1'b0, op_b};
        case (mode)
            0:       begin approx_sum = ex_sum[15:0];          approx_co = ex_sum[16]; end
            1:       begin approx_sum = ex_sum[15:0] ^ 16'h1;  approx_co = ex_sum[16]; end
            2:       begin approx_sum = ex_sum[15:0];          approx_co = 1'b0;       end
            default: begin approx_sum = op_a;                  approx_co = 1'b0;       end
        endcase
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    function automatic logic [16:0] model_ed(input logic [15:0] a, input logic [15:0] b,
                                             input int md);
        logic [16:0] ex;
        logic [15:0] s;
        logic        c;
        logic [16:0] x;
        logic [16:0] y;
        ex = {1'b0, a} + {1'b0, b};
        case (md)
            0:       begin s = ex[15:0];         c = ex[16]; end
            1:       begin s = ex[15:0] ^ 16'h1; c = ex[16]; end
            2:       begin s = ex[15:0];         c = 1'b0;   end
            default: begin s = a;                c = 1'b0;   end
        endcase
`ifdef APPROX_CARRY_CHECK_EN
        x = ex;
        y = {c, s};
`else
        x = {1'b0, ex[15:0]};
        y = {c & 1'b0, s};
`endif
        return (x >= y) ? (x - y) : (y - x);
    endfunction

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
    } pair_t;

    pair_t       exp_q[$];
    logic [15:0] last_a = '0;
    logic [15:0] last_b = '0;

    task automatic push_pairs(input logic [31:0] sd, input int unsigned m);
        logic [31:0] s;
        pair_t p;
        s = (sd == 32'h0) ? 32'h1 : sd;
        for (int unsigned i = 0; i < m; i++) begin
            p.a = s[15:0];
            p.b = s[31:16];
            exp_q.push_back(p);
            s = lfsr_step(s);
        end
    endtask

    task automatic model_counts(input logic [31:0] sd, input int unsigned m, input int md,
                                output logic [31:0] e_err, output logic [47:0] e_tot,
                                output logic [16:0] e_max);
        logic [31:0] s;
        logic [16:0] ed;
        s = (sd == 32'h0) ? 32'h1 : sd;
        e_err = '0;
        e_tot = '0;
        e_max = '0;
        for (int unsigned i = 0; i < m; i++) begin
            ed = model_ed(s[15:0], s[31:16], md);
            if (ed != 17'h0) e_err = e_err + 32'h1;
            e_tot = e_tot + 48'(ed);
            if (ed > e_max) e_max = ed;
            s = lfsr_step(s);
        end
    endtask

    typedef struct {
        int unsigned m;
        logic [31:0] sd;
        int          md;
        logic [31:0] e_err;
        logic [47:0] e_tot;
        logic [16:0] e_max;
        bit          glitch;
    } vec_t;

    task automatic run_vec(input vec_t v);
        int    cycles;
        pair_t p;
        @(negedge clk);
        mode      = v.md;
        num_tests = v.m;
        seed      = v.sd;
        start     = 1'b1;
        push_pairs(v.sd, v.m);
        @(posedge clk);
        #1;
        start     = 1'b0;
        num_tests = $urandom;
        seed      = $urandom;
        cycles    = 1;
        if (v.m == 0) begin
            chk("busy_zero_run", 64'(busy), 64'h0);
            chk("done_zero_run", 64'(done), 64'h1);
            chk("ops_hold", {32'h0, op_a, op_b}, {32'h0, last_a, last_b});
        end else begin
            chk("busy_after_start", 64'(busy), 64'h1);
            chk("done_drop", 64'(done), 64'h0);
        end
        for (int unsigned j = 1; j <= v.m; j++) begin
            @(posedge clk);
            #1;
            cycles++;
            if (v.glitch && j == 2) start = 1'b1;
            if (v.glitch && j == 3) start = 1'b0;
            if (exp_q.size() == 0) begin
                chk("scoreboard_empty", 64'h1, 64'h0);
            end else begin
                p = exp_q.pop_front();
                chk("ops", {32'h0, op_a, op_b}, {32'h0, p.a, p.b});
                last_a = p.a;
                last_b = p.b;
            end
        end
        start = 1'b0;
        while (!done && cycles < int'(v.m) + 20) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        chk("done_latency", 64'(cycles), (v.m == 0) ? 64'd1 : 64'(v.m + 3));
        chk("busy_in_done", 64'(busy), 64'h0);
        chk("err_cnt", 64'(err_cnt), 64'(v.e_err));
        chk("total_ed", 64'(total_ed), 64'(v.e_tot));
        chk("max_ed", 64'(max_ed), 64'(v.e_max));
        chk("tests_run", 64'(tests_run), 64'(v.m));
    endtask

    vec_t vecs[8];

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        num_tests = '0;
        seed      = '0;
        mode      = 0;

        vecs[0] = '{1000, 32'h0000_ACE1, 0, 32'd0,   48'd0,   17'd0, 1'b0};
        vecs[1] = '{500,  32'h1234_5678, 1, 32'd500, 48'd500, 17'd1, 1'b0};
        vecs[2] = '{0,    32'h0000_0005, 0, 32'd0,   48'd0,   17'd0, 1'b0};
        vecs[3] = '{4,    32'h0000_0000, 0, 32'd0,   48'd0,   17'd0, 1'b0};
        vecs[4] = '{4,    32'h0000_0001, 0, 32'd0,   48'd0,   17'd0, 1'b1};
        vecs[5] = '{256,  32'h0000_BEEF, 2, 32'd0,   48'd0,   17'd0, 1'b0};
        vecs[6] = '{1,    32'h0000_DEAD, 1, 32'd1,   48'd1,   17'd1, 1'b0};
        vecs[7] = '{64,   32'hC0FF_EE11, 3, 32'd0,   48'd0,   17'd0, 1'b0};
`ifdef APPROX_CARRY_CHECK_EN
        model_counts(vecs[5].sd, vecs[5].m, vecs[5].md, vecs[5].e_err, vecs[5].e_tot,
                     vecs[5].e_max);
`endif
        model_counts(vecs[7].sd, vecs[7].m, vecs[7].md, vecs[7].e_err, vecs[7].e_tot,
                     vecs[7].e_max);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_done", 64'(done), 64'h0);
        chk("rst_ops", {32'h0, op_a, op_b}, 64'h0);
        chk("rst_counters", 64'(err_cnt) | 64'(total_ed) | 64'(max_ed) | 64'(tests_run), 64'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i]);
        end

        // Reset in the middle of a long run
        @(negedge clk);
        mode      = 1;
        num_tests = 100;
        seed      = 32'h0000_1357;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (50) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_busy", 64'(busy), 64'h0);
        chk("midrst_done", 64'(done), 64'h0);
        chk("midrst_ops", {32'h0, op_a, op_b}, 64'h0);
        chk("midrst_tests_run", 64'(tests_run), 64'h0);
        chk("midrst_counters", 64'(err_cnt) | 64'(total_ed) | 64'(max_ed), 64'h0);
        @(negedge clk);
        rst    = 1'b0;
        last_a = '0;
        last_b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_flushed", 64'(tests_run), 64'h0);
        chk("midrst_no_done", 64'(done), 64'h0);
        run_vec('{10, 32'h0000_1357, 1, 32'd10, 48'd10, 17'd1, 1'b0});

        chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
